// File: rtl/truth_tbl1_pkg.sv
`default_nettype none
// ============================================================================
// Module      : truth_tbl1_pkg
// Description : Shared definitions for the truth-table preimage enumerator.
//               Holds the controller state encoding, the default truth table
//               and the minterm index width.
// Revision    : 1.0 - initial release
// ============================================================================
package truth_tbl1_pkg;

    // Three-input function -> 8 minterms, 3-bit index {a,b,c}.
    localparam int IDX_W     = 3;
    localparam int N_MINTERM = 1 << IDX_W;

    // f=1 at 000,001,010,100,111; f=0 at 011,101,110.
    localparam logic [N_MINTERM-1:0] TRUTH_TBL1_DEFAULT = 8'h97;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_EMPTY = 2'd2
    } state_t;

endpackage : truth_tbl1_pkg
`default_nettype wire

// File: rtl/truth_tbl1_next_match.sv
`default_nettype none
// ============================================================================
// Module      : truth_tbl1_next_match
// Description : Combinational search for the lowest minterm index >= from_idx
//               whose table entry equals target.
//               Ports:
//                 tbl       in  8  truth table, bit i = f({a,b,c}=i)
//                 target    in  1  f value searched for
//                 from_idx  in  3  lowest index considered
//                 match_idx out 3  lowest matching index (0 when none)
//                 found     out 1  at least one match at or above from_idx
//                 last      out 1  match_idx is the only match at or above
//                                  from_idx
// Revision    : 1.0 - initial release
// ============================================================================
module truth_tbl1_next_match
    import truth_tbl1_pkg::*;
(
    input  logic [N_MINTERM-1:0] tbl,
    input  logic                 target,
    input  logic [IDX_W-1:0]     from_idx,
    output logic [IDX_W-1:0]     match_idx,
    output logic                 found,
    output logic                 last
);

    logic [N_MINTERM-1:0] w_mask;

    always_comb begin
        w_mask    = '0;
        match_idx = '0;
        for (int i = 0; i < N_MINTERM; i++) begin
            w_mask[i] = (tbl[i] == target) && (i >= int'(from_idx));
        end
        // Scan downward so the lowest set bit wins.
        for (int i = N_MINTERM - 1; i >= 0; i--) begin
            if (w_mask[i]) begin
                match_idx = i[IDX_W-1:0];
            end
        end
        found = |w_mask;
        // Exactly one bit set <=> clearing the lowest set bit leaves zero.
        last  = found && ((w_mask & (w_mask - 1'b1)) == '0);
    end

endmodule : truth_tbl1_next_match
`default_nettype wire

// File: rtl/truth_tbl1_preimage_enum.sv
`default_nettype none
// ============================================================================
// Module      : truth_tbl1_preimage_enum
// Description : Enumerates, in ascending order, every input combination
//               {a,b,c} for which the 3-input truth table TBL yields the
//               requested output value. A request with no preimage produces a
//               single "empty" response.
//               Ports:
//                 clk         in  1  clock, rising edge
//                 reset_n     in  1  asynchronous active-low reset
//                 req_val     in  1  request valid
//                 req_rdy     out 1  request ready (IDLE only)
//                 req_target  in  1  f value to enumerate
//                 resp_val    out 1  response valid
//                 resp_rdy    in  1  response ready
//                 resp_abc    out 3  matching {a,b,c}
//                 resp_last   out 1  final response of the request
//                 resp_empty  out 1  request had no preimage
//               Build option: TRUTH_TBL1_PREIMAGE_SKIP_EN - jump directly
//               between matching indices (no bubble cycles in SCAN).
// Revision    : 1.0 - initial release
// ============================================================================
module truth_tbl1_preimage_enum
    import truth_tbl1_pkg::*;
#(
    parameter logic [N_MINTERM-1:0] TBL = TRUTH_TBL1_DEFAULT
)
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_val,
    output logic             req_rdy,
    input  logic             req_target,
    output logic             resp_val,
    input  logic             resp_rdy,
    output logic [IDX_W-1:0] resp_abc,
    output logic             resp_last,
    output logic             resp_empty
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             r_target;
    logic             w_target_nxt;

    // Shared search: in IDLE it looks at the incoming request from index 0
    // (empty detection / first match); elsewhere it looks at the latched
    // target from the current index (resp_last). The IDLE-side result only
    // feeds next-state logic, so no combinational req->resp path exists.
    logic             w_nm_target;
    logic [IDX_W-1:0] w_nm_from;
    logic [IDX_W-1:0] w_cur_idx;
    logic             w_cur_found;
    logic             w_cur_last;
    logic             w_cur_match;

    logic [IDX_W-1:0] w_first_idx;  // idx loaded on accept
    logic [IDX_W-1:0] w_step_idx;   // idx after a bubble or non-last fire

    assign w_nm_target = (r_state == ST_IDLE) ? req_target : r_target;
    assign w_nm_from   = (r_state == ST_IDLE) ? '0 : r_idx;
    assign w_cur_match = (TBL[r_idx] == r_target);

    truth_tbl1_next_match u_cur_match (
        .tbl       (TBL),
        .target    (w_nm_target),
        .from_idx  (w_nm_from),
        .match_idx (w_cur_idx),
        .found     (w_cur_found),
        .last      (w_cur_last)
    );

`ifdef TRUTH_TBL1_PREIMAGE_SKIP_EN
    logic [IDX_W-1:0] w_skip_idx;
    logic             w_skip_found;
    logic             w_skip_last;
    logic             w_unused_skip;

    // Searching from idx+1 wraps at 7, but that only happens on the last
    // fire, where the step value is not used.
    truth_tbl1_next_match u_skip_match (
        .tbl       (TBL),
        .target    (r_target),
        .from_idx  (r_idx + 1'b1),
        .match_idx (w_skip_idx),
        .found     (w_skip_found),
        .last      (w_skip_last)
    );

    assign w_unused_skip = w_skip_found ^ w_skip_last;
    assign w_first_idx   = w_cur_idx;
    assign w_step_idx    = w_skip_idx;
`else
    logic w_unused_cur;

    assign w_unused_cur = ^w_cur_idx;
    assign w_first_idx  = '0;
    assign w_step_idx   = r_idx + 1'b1;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Enumeration index and latched target
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx    <= '0;
            r_target <= 1'b0;
        end else begin
            r_idx    <= w_idx_nxt;
            r_target <= w_target_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_target_nxt = r_target;
        case (r_state)
            ST_IDLE: begin
                if (req_val) begin
                    w_target_nxt = req_target;
                    if (!w_cur_found) begin
                        w_state_nxt = ST_EMPTY;
                        w_idx_nxt   = '0;
                    end else begin
                        w_state_nxt = ST_SCAN;
                        w_idx_nxt   = w_first_idx;
                    end
                end
            end
            ST_SCAN: begin
                if (!w_cur_match) begin
                    // Bubble: no response at this index, move on.
                    w_idx_nxt = w_step_idx;
                end else if (resp_rdy) begin
                    if (w_cur_last) begin
                        w_state_nxt = ST_IDLE;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = w_step_idx;
                    end
                end
            end
            ST_EMPTY: begin
                if (resp_rdy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        req_rdy    = 1'b0;
        resp_val   = 1'b0;
        resp_abc   = '0;
        resp_last  = 1'b0;
        resp_empty = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_rdy = 1'b1;
            end
            ST_SCAN: begin
                resp_val  = w_cur_match;
                resp_abc  = r_idx;
                // When the current index matches, the search from r_idx
                // returns r_idx itself, so its last flag is ours.
                resp_last = w_cur_match && w_cur_last;
            end
            ST_EMPTY: begin
                resp_val   = 1'b1;
                resp_last  = 1'b1;
                resp_empty = 1'b1;
            end
            default: begin
                req_rdy = 1'b0;
            end
        endcase
    end

endmodule : truth_tbl1_preimage_enum
`default_nettype wire

// File: tb/tb_truth_tbl1_preimage_enum.sv
`default_nettype none
// ============================================================================
// Module      : tb_truth_tbl1_preimage_enum
// Description : Directed self-checking bench for truth_tbl1_preimage_enum.
//               Drives the default table and an all-ones table and checks
//               the response stream cycle by cycle against hand-computed
//               expectations. Honours TRUTH_TBL1_PREIMAGE_SKIP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_tbl1_preimage_enum;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req_val, req_target, resp_rdy;
    logic       req_rdy, resp_val, resp_last, resp_empty;
    logic [2:0] resp_abc;

    logic       ff_req_val, ff_req_target, ff_resp_rdy;
    logic       ff_req_rdy, ff_resp_val, ff_resp_last, ff_resp_empty;
    logic [2:0] ff_resp_abc;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected per-cycle stream after an accept: >=0 response abc,
    // -1 bubble in SCAN, -2 back in IDLE.
    int exp_q[$];

    always #5 clk = ~clk;

    truth_tbl1_preimage_enum dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_val    (req_val),
        .req_rdy    (req_rdy),
        .req_target (req_target),
        .resp_val   (resp_val),
        .resp_rdy   (resp_rdy),
        .resp_abc   (resp_abc),
        .resp_last  (resp_last),
        .resp_empty (resp_empty)
    );

    truth_tbl1_preimage_enum #(.TBL(8'hFF)) dut_ff (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_val    (ff_req_val),
        .req_rdy    (ff_req_rdy),
        .req_target (ff_req_target),
        .resp_val   (ff_resp_val),
        .resp_rdy   (ff_resp_rdy),
        .resp_abc   (ff_resp_abc),
        .resp_last  (ff_resp_last),
        .resp_empty (ff_resp_empty)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Issue a request on dut; returns at posedge+1 of the accept edge.
    // req_target is then flipped to prove the latched copy is used.
    task automatic request(input logic tgt);
        req_val    = 1'b1;
        req_target = tgt;
        @(negedge clk);
        check("req_rdy_before_accept", {7'd0, req_rdy}, 8'd1);
        @(posedge clk);
        #1;
        req_val    = 1'b0;
        req_target = ~tgt;
    endtask

    // Walk exp_q cycle by cycle. resp_rdy is low for the first n_low cycles.
    // hold_req keeps req_val asserted while the DUT is busy.
    task automatic run_seq(input string tag, input int n_low, input bit hold_req);
        int last_abc;
        int e;
        last_abc = -3;
        foreach (exp_q[k]) if (exp_q[k] >= 0) last_abc = exp_q[k];
        for (int i = 0; i < exp_q.size(); i++) begin
            e        = exp_q[i];
            resp_rdy = (i >= n_low);
            req_val  = hold_req && (e != -2);
            @(negedge clk);
            if (e == -2) begin
                check($sformatf("%s_c%0d_rdy", tag, i + 1), {7'd0, req_rdy}, 8'd1);
                check($sformatf("%s_c%0d_val", tag, i + 1), {7'd0, resp_val}, 8'd0);
            end else if (e == -1) begin
                check($sformatf("%s_c%0d_val", tag, i + 1), {7'd0, resp_val}, 8'd0);
                check($sformatf("%s_c%0d_rdy", tag, i + 1), {7'd0, req_rdy}, 8'd0);
            end else begin
                check($sformatf("%s_c%0d_val", tag, i + 1), {7'd0, resp_val}, 8'd1);
                check($sformatf("%s_c%0d_abc", tag, i + 1), {5'd0, resp_abc}, e[7:0]);
                check($sformatf("%s_c%0d_last", tag, i + 1), {7'd0, resp_last},
                      (e == last_abc) ? 8'd1 : 8'd0);
                check($sformatf("%s_c%0d_empty", tag, i + 1), {7'd0, resp_empty}, 8'd0);
            end
            @(posedge clk);
            #1;
        end
        req_val  = 1'b0;
        resp_rdy = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        req_val       = 1'b0;
        req_target    = 1'b0;
        resp_rdy      = 1'b1;
        ff_req_val    = 1'b0;
        ff_req_target = 1'b0;
        ff_resp_rdy   = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_rdy",    {7'd0, req_rdy},    8'd1);
        check("rst_resp_val",   {7'd0, resp_val},   8'd0);
        check("rst_resp_abc",   {5'd0, resp_abc},   8'd0);
        check("rst_resp_last",  {7'd0, resp_last},  8'd0);
        check("rst_resp_empty", {7'd0, resp_empty}, 8'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // target=1, full-speed consumer
        request(1'b1);
`ifdef TRUTH_TBL1_PREIMAGE_SKIP_EN
        exp_q = '{0, 1, 2, 4, 7, -2};
`else
        exp_q = '{0, 1, 2, -1, 4, -1, -1, 7, -2};
`endif
        run_seq("t1", 0, 1'b0);

        // target=0 with a competing request held high (must be ignored)
        request(1'b0);
`ifdef TRUTH_TBL1_PREIMAGE_SKIP_EN
        exp_q = '{3, 5, 6, -2};
`else
        exp_q = '{-1, -1, -1, 3, -1, 5, 6, -2};
`endif
        run_seq("t0_hold", 0, 1'b1);

        // target=0 with backpressure: 011 held for three cycles
        request(1'b0);
`ifdef TRUTH_TBL1_PREIMAGE_SKIP_EN
        exp_q = '{3, 3, 3, 3, 5, 6, -2};
        run_seq("t0_bp", 3, 1'b0);
`else
        exp_q = '{-1, -1, -1, 3, 3, 3, 3, -1, 5, 6, -2};
        run_seq("t0_bp", 6, 1'b0);
`endif

        // All-ones table, target=0 -> single empty response
        ff_req_val    = 1'b1;
        ff_req_target = 1'b0;
        @(negedge clk);
        check("ff_req_rdy", {7'd0, ff_req_rdy}, 8'd1);
        @(posedge clk);
        #1;
        ff_req_val = 1'b0;
        @(negedge clk);
        check("ff_empty_val",   {7'd0, ff_resp_val},   8'd1);
        check("ff_empty_flag",  {7'd0, ff_resp_empty}, 8'd1);
        check("ff_empty_last",  {7'd0, ff_resp_last},  8'd1);
        check("ff_empty_abc",   {5'd0, ff_resp_abc},   8'd0);
        check("ff_empty_rdy",   {7'd0, ff_req_rdy},    8'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("ff_idle_rdy",    {7'd0, ff_req_rdy},    8'd1);
        check("ff_idle_val",    {7'd0, ff_resp_val},   8'd0);
        check("ff_idle_empty",  {7'd0, ff_resp_empty}, 8'd0);

        // Reset in the middle of a target=1 enumeration
        @(posedge clk);
        #1;
        request(1'b1);
        @(negedge clk);
        check("mid_c1_abc", {5'd0, resp_abc}, 8'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_c2_val", {7'd0, resp_val}, 8'd1);
        check("mid_c2_abc", {5'd0, resp_abc}, 8'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_val",  {7'd0, resp_val},  8'd0);
        check("mid_rst_rdy",  {7'd0, req_rdy},   8'd1);
        check("mid_rst_abc",  {5'd0, resp_abc},  8'd0);
        check("mid_rst_last", {7'd0, resp_last}, 8'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_rdy", {7'd0, req_rdy},  8'd1);
        check("post_rst_val", {7'd0, resp_val}, 8'd0);
        @(posedge clk);
        #1;
        request(1'b0);
`ifdef TRUTH_TBL1_PREIMAGE_SKIP_EN
        exp_q = '{3, 5, 6, -2};
`else
        exp_q = '{-1, -1, -1, 3, -1, 5, 6, -2};
`endif
        run_seq("post_rst_t0", 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_truth_tbl1_preimage_enum
`default_nettype wire
